uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between two byte-stream requesters: the CPU memory-mapped store path and a debug/exception reporter. Each requester has its own small FIFO. The arbiter grants the UART to one source per packet, alternates sources round-robin, and releases a stalled owner after a timeout. It sits between the memory map's TX output and the UART's DataIn/DataInValid/DataInReady.

Parameters:
FIFO_DEPTH, 4, entries per source FIFO; power of two, at least 2.
TIMEOUT_CYCLES, 64, consecutive cycles an owner's FIFO may stay empty mid-packet before the grant is revoked; at least 1.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
cpu_data  input  8  CPU TX byte
cpu_valid  input  1  CPU byte offered
cpu_last  input  1  byte ends the CPU packet
cpu_ready  output  1  CPU FIFO can accept; equals not-full
dbg_data  input  8  debug TX byte
dbg_valid  input  1  debug byte offered
dbg_last  input  1  byte ends the debug packet
dbg_ready  output  1  debug FIFO can accept; equals not-full
uart_data  output  8  byte to UART DataIn
uart_valid  output  1  to UART DataInValid
uart_ready  input  1  from UART DataInReady
grant  output  2  one-hot owner: bit0 = CPU, bit1 = debug; 00 when idle
busy  output  1  high in SEND state

Behaviour:
- Reset (async, active-high):
  - FIFOs emptied; state IDLE; round-robin preference set to CPU; timeout counter 0.
  - uart_valid=0, uart_data=0, grant=00, busy=0.
  - cpu_ready and dbg_ready read 1 as soon as reset asserts.
- Source FIFOs:
  - Entries are {last, data}, 9 bits wide.
  - Push on valid&&ready. valid while full is not accepted; the producer must hold its byte.
  - No full-bypass.
  - Push and pop in the same cycle on a non-empty FIFO: both occur, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- IDLE:
  - If exactly one FIFO is non-empty, grant that source.
  - If both are non-empty, grant the preferred source.
  - On grant, register the owner and go to SEND; otherwise stay in IDLE.
- SEND:
  - uart_valid = owner FIFO not empty.
  - uart_data = owner head data; 0 when the FIFO is empty.
  - Pop when uart_valid&&uart_ready.
  - If the popped entry has last=1, go to IDLE next cycle, grant=00, and set preference to the other source.
  - The non-owner FIFO keeps accepting pushes but is never drained.
- Timeout:
  - In SEND, the counter increments each cycle the owner FIFO is empty.
  - It clears on any pop and on entry to SEND.
  - When it reaches TIMEOUT_CYCLES-1 while the FIFO is still empty: go to IDLE, flip preference, clear the counter.
  - Any bytes the owner pushes afterwards start a new arbitration.
- Latency:
  - A byte pushed into an empty FIFO at edge E0 while IDLE: grant registered at E1, uart_valid high after E1.
  - Back-to-back bytes from the owner sustain one byte per cycle while uart_ready=1.
- uart_valid never depends combinationally on uart_ready. uart_data is held stable while valid && !ready.
- Reset mid-packet aborts the packet. Bytes still in the FIFOs are discarded.

Decomposition:
- Package mips150_io_pkg holds:
  - state encoding (IDLE, SEND)
  - source IDs (SRC_CPU=0, SRC_DBG=1)
  - FIFO entry width constant (9)
- One sub-module, io_sync_fifo (parameterised width/depth, async reset), instantiated twice.
- Arbiter FSM and timeout counter live in the top.

Test Plan:
- Single packet: reset, then CPU pushes 0x41, 0x42, 0x43 (last on 0x43) with uart_ready=1 → grant=01 one edge after the first push; uart_data 0x41, 0x42, 0x43 on consecutive cycles; grant=00 and busy=0 after the last pop.
- Contention: both FIFOs hold one packet (CPU 0x11,0x12 last; debug 0x21 last) at reset release → order 0x11, 0x12, 0x21; next pair of packets → debug first, then CPU.
- Backpressure/full: FIFO_DEPTH=4, uart_ready=0, CPU pushes 6 bytes → cpu_ready drops after 4 accepted, uart_data holds 0x00-indexed first byte; raise uart_ready → all 4 sent in order, cpu_ready returns to 1.
- Timeout: CPU sends 0x55 without last, then idles; debug has 0x66 last queued → grant revoked exactly TIMEOUT_CYCLES empty cycles after the pop; grant=10 one cycle later; 0x66 sent.
- Wrap-around: 3×FIFO_DEPTH single-byte CPU packets streamed → output sequence matches input exactly; no drops or duplicates.
- Reset mid-packet: assert rst while uart_valid=1 with 2 bytes queued → outputs 0 immediately (asynchronously); after release no stale byte appears; a fresh packet is sent correctly.

Source files
------------

// File: rtl/mips150_io_pkg.sv
// Shared types for the UART transmit arbiter.
// Contents:
//   arb_state_e  - arbiter state (IDLE, SEND)
//   src_e        - requester IDs (CPU = 0, debug = 1)
//   EntryW       - source FIFO entry width: {last, data[7:0]}
//   src_onehot() - owner ID to one-hot grant vector
//   other_src()  - the requester that is not the given one
package mips150_io_pkg;

  typedef enum logic [0:0] {StIdle, StSend} arb_state_e;

  typedef enum logic [0:0] {SrcCpu = 1'b0, SrcDbg = 1'b1} src_e;

  localparam int unsigned EntryW = 9;

  function automatic logic [1:0] src_onehot(src_e s);
    return (s == SrcDbg) ? 2'b10 : 2'b01;
  endfunction

  function automatic src_e other_src(src_e s);
    return (s == SrcDbg) ? SrcCpu : SrcDbg;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two byte producers, the arbiter and the UART.
// Signals:
//   cpu_data/cpu_valid/cpu_last, cpu_ready - CPU store-path byte stream
//   dbg_data/dbg_valid/dbg_last, dbg_ready - debug reporter byte stream
//   uart_data/uart_valid, uart_ready       - UART DataIn/DataInValid/DataInReady
//   grant, busy                            - arbiter status
// Modports: slave = arbiter side, master = producers/UART side.
interface uart_tx_arbiter_if;
  logic [7:0] cpu_data;
  logic       cpu_valid;
  logic       cpu_last;
  logic       cpu_ready;
  logic [7:0] dbg_data;
  logic       dbg_valid;
  logic       dbg_last;
  logic       dbg_ready;
  logic [7:0] uart_data;
  logic       uart_valid;
  logic       uart_ready;
  logic [1:0] grant;
  logic       busy;

  modport slave (
    input  cpu_data, cpu_valid, cpu_last, dbg_data, dbg_valid, dbg_last, uart_ready,
    output cpu_ready, dbg_ready, uart_data, uart_valid, grant, busy
  );

  modport master (
    output cpu_data, cpu_valid, cpu_last, dbg_data, dbg_valid, dbg_last, uart_ready,
    input  cpu_ready, dbg_ready, uart_data, uart_valid, grant, busy
  );
endinterface

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with asynchronous active-high reset.
// Ports:
//   clk, rst           - clock, async reset (empties the FIFO)
//   push_i, wdata_i    - write; ignored while full (no full-bypass)
//   pop_i, rdata_o     - read; rdata_o shows the head, valid while !empty_o
//   full_o, empty_o    - occupancy flags
// Depth must be a power of two so the pointers wrap naturally.
module io_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic [Width-1:0] mem_q [Depth];
  logic             push_en, pop_en;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the CPU store path and the debug reporter.
// Each source has its own FIFO; the UART is granted per packet (ended by last=1),
// round-robin between sources, and an owner whose FIFO stays empty mid-packet for
// TIMEOUT_CYCLES cycles loses the grant.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   bus      - slave side of uart_tx_arbiter_if (producers, UART, grant/busy)
module uart_tx_arbiter
  import mips150_io_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  arb_state_e  state_q, state_d;
  src_e        owner_q, owner_d;
  src_e        pref_q, pref_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [EntryW-1:0] cpu_head, dbg_head, owner_head;
  logic cpu_full, cpu_empty, dbg_full, dbg_empty, owner_empty;
  logic cpu_pop, dbg_pop, pop;
  logic uart_valid;
  logic [7:0] uart_data;

  io_sync_fifo #(.Width(EntryW), .Depth(FIFO_DEPTH)) u_cpu_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.cpu_valid),
    .wdata_i ({bus.cpu_last, bus.cpu_data}),
    .pop_i   (cpu_pop),
    .rdata_o (cpu_head),
    .full_o  (cpu_full),
    .empty_o (cpu_empty)
  );

  io_sync_fifo #(.Width(EntryW), .Depth(FIFO_DEPTH)) u_dbg_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.dbg_valid),
    .wdata_i ({bus.dbg_last, bus.dbg_data}),
    .pop_i   (dbg_pop),
    .rdata_o (dbg_head),
    .full_o  (dbg_full),
    .empty_o (dbg_empty)
  );

  assign owner_empty = (owner_q == SrcDbg) ? dbg_empty : cpu_empty;
  assign owner_head  = (owner_q == SrcDbg) ? dbg_head : cpu_head;
  assign cpu_pop     = pop && (owner_q == SrcCpu);
  assign dbg_pop     = pop && (owner_q == SrcDbg);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    pref_d     = pref_q;
    cnt_d      = cnt_q;
    uart_valid = 1'b0;
    uart_data  = 8'h00;
    pop        = 1'b0;
    case (state_q)
      StIdle: begin
        if (!cpu_empty || !dbg_empty) begin
          if (!cpu_empty && !dbg_empty) owner_d = pref_q;
          else if (!cpu_empty)          owner_d = SrcCpu;
          else                          owner_d = SrcDbg;
          state_d = StSend;
          cnt_d   = '0;
        end
      end
      StSend: begin
        // Valid depends only on FIFO occupancy, never on uart_ready.
        uart_valid = !owner_empty;
        uart_data  = owner_empty ? 8'h00 : owner_head[7:0];
        pop        = uart_valid && bus.uart_ready;
        if (pop) begin
          cnt_d = '0;
          if (owner_head[8]) begin
            state_d = StIdle;
            pref_d  = other_src(owner_q);
          end
        end else if (owner_empty) begin
          if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StIdle;
            pref_d  = other_src(owner_q);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= SrcCpu;
      pref_q  <= SrcCpu;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pref_q  <= pref_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.cpu_ready  = !cpu_full;
  assign bus.dbg_ready  = !dbg_full;
  assign bus.uart_valid = uart_valid;
  assign bus.uart_data  = uart_data;
  assign bus.grant      = (state_q == StSend) ? src_onehot(owner_q) : 2'b00;
  assign bus.busy       = (state_q == StSend);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// contention rounds checked against a packet-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 8;

  logic clk;
  logic rst;
  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.FIFO_DEPTH(Depth), .TIMEOUT_CYCLES(Timeout)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int pref_m;              // model preference: 0 = CPU, 1 = debug
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Record every byte the UART accepts; sampled mid-cycle, taken at the next edge.
  always @(negedge clk) begin
    if (!rst && bus.uart_valid && bus.uart_ready) got_q.push_back(bus.uart_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_valid = 1'b0;
    bus.cpu_last  = 1'b0;
    bus.cpu_data  = 8'h00;
    bus.dbg_valid = 1'b0;
    bus.dbg_last  = 1'b0;
    bus.dbg_data  = 8'h00;
  endtask

  task automatic wait_got(input int n, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      bus.uart_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    if (got_q.size() >= n) ok = 1'b1;
    bus.uart_ready = 1'b1;
  endtask

  task automatic compare_stream(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= got_q.size()) begin
        n_err++;
        $display("FAIL %s[%0d]: got no byte, expected %h", name, i, exp_q[i]);
      end else if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s[%0d]: got %h, expected %h", name, i, got_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s count: got %0d, expected %0d", name, got_q.size(), exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    bus.uart_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
    pref_m = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.uart_ready = 1'b0;
    #3;
    n_vec += 6;
    if (bus.cpu_ready !== 1'b1) begin n_err++; $display("FAIL rst cpu_ready: got %b, expected 1", bus.cpu_ready); end
    if (bus.dbg_ready !== 1'b1) begin n_err++; $display("FAIL rst dbg_ready: got %b, expected 1", bus.dbg_ready); end
    if (bus.uart_valid !== 1'b0) begin n_err++; $display("FAIL rst uart_valid: got %b, expected 0", bus.uart_valid); end
    if (bus.uart_data !== 8'h00) begin n_err++; $display("FAIL rst uart_data: got %h, expected 00", bus.uart_data); end
    if (bus.grant !== 2'b00) begin n_err++; $display("FAIL rst grant: got %b, expected 00", bus.grant); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst busy: got %b, expected 0", bus.busy); end
    do_reset();
  endtask

  task automatic test_single_packet();
    logic [7:0] seq [3];
    seq[0] = 8'h41; seq[1] = 8'h42; seq[2] = 8'h43;
    got_q.delete();
    bus.uart_ready = 1'b1;
    bus.cpu_valid = 1'b1; bus.cpu_data = seq[0]; bus.cpu_last = 1'b0;
    tick();  // E0: first push
    n_vec++;
    if (bus.grant !== 2'b00) begin n_err++; $display("FAIL single grant@E0: got %b, expected 00", bus.grant); end
    bus.cpu_data = seq[1];
    tick();  // E1: grant
    n_vec += 2;
    if (bus.grant !== 2'b01) begin n_err++; $display("FAIL single grant@E1: got %b, expected 01", bus.grant); end
    if (bus.uart_valid !== 1'b1) begin n_err++; $display("FAIL single valid@E1: got %b, expected 1", bus.uart_valid); end
    bus.cpu_data = seq[2]; bus.cpu_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (bus.uart_data !== seq[i]) begin
        n_err++;
        $display("FAIL single data[%0d]: got %h, expected %h", i, bus.uart_data, seq[i]);
      end
      tick();
      idle_inputs();
    end
    n_vec += 2;
    if (bus.grant !== 2'b00) begin n_err++; $display("FAIL single grant end: got %b, expected 00", bus.grant); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single busy end: got %b, expected 0", bus.busy); end
    pref_m = 1;
    exp_q.delete();
    foreach (seq[i]) exp_q.push_back(seq[i]);
    compare_stream("single");
  endtask

  // Pushes one CPU packet and one debug packet in parallel with the UART stalled,
  // then drains with the given ready pattern. The model orders whole packets.
  task automatic run_pair(input string name, input int lc, input int ld,
                          input logic [7:0] cd [4], input logic [7:0] dd [4], input bit rnd);
    int first;
    bit ok;
    got_q.delete();
    exp_q.delete();
    bus.uart_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cpu_valid = (i < lc); bus.cpu_data = cd[i]; bus.cpu_last = (i == lc - 1);
      bus.dbg_valid = (i < ld); bus.dbg_data = dd[i]; bus.dbg_last = (i == ld - 1);
      tick();
    end
    idle_inputs();
    first = (lc > 0 && ld > 0) ? pref_m : ((lc > 0) ? 0 : 1);
    n_vec++;
    if (bus.grant !== ((first == 1) ? 2'b10 : 2'b01)) begin
      n_err++;
      $display("FAIL %s grant: got %b, expected src %0d", name, bus.grant, first);
    end
    for (int p = 0; p < 2; p++) begin
      int s;
      s = (p == 0) ? first : 1 - first;
      if ((s == 0 && lc > 0) || (s == 1 && ld > 0)) begin
        for (int i = 0; i < ((s == 0) ? lc : ld); i++) exp_q.push_back((s == 0) ? cd[i] : dd[i]);
        pref_m = 1 - s;
      end
    end
    wait_got(exp_q.size(), rnd, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL %s drain: got %0d bytes, expected %0d", name, got_q.size(), exp_q.size()); end
    repeat (2) tick();
    compare_stream(name);
    n_vec++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL %s idle busy: got %b, expected 0", name, bus.busy); end
  endtask

  task automatic test_contention();
    logic [7:0] cd [4];
    logic [7:0] dd [4];
    do_reset();
    cd = '{8'h11, 8'h12, 8'h00, 8'h00};
    dd = '{8'h21, 8'h00, 8'h00, 8'h00};
    run_pair("contend1", 2, 1, cd, dd, 1'b0);
    cd = '{8'h13, 8'h14, 8'h00, 8'h00};
    dd = '{8'h22, 8'h00, 8'h00, 8'h00};
    run_pair("contend2", 2, 1, cd, dd, 1'b0);
  endtask

  task automatic test_random_rr();
    logic [7:0] cd [4];
    logic [7:0] dd [4];
    int lc, ld;
    for (int r = 0; r < 10; r++) begin
      lc = $urandom_range(0, 4);
      ld = $urandom_range(0, 4);
      if (lc == 0 && ld == 0) lc = 1;
      for (int i = 0; i < 4; i++) begin
        cd[i] = 8'($urandom_range(0, 255));
        dd[i] = 8'($urandom_range(0, 255));
      end
      run_pair("random_rr", lc, ld, cd, dd, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    int held;
    bit ok;
    got_q.delete();
    exp_q.delete();
    bus.uart_ready = 1'b0;
    held = 0;
    for (int i = 0; i < 6; i++) begin
      bus.cpu_valid = 1'b1;
      bus.cpu_data  = 8'h30 + 8'(i);
      bus.cpu_last  = (i == 3);
      n_vec++;
      if (bus.cpu_ready !== (held < Depth)) begin
        n_err++;
        $display("FAIL bp cpu_ready[%0d]: got %b, expected %b", i, bus.cpu_ready, held < Depth);
      end
      if (held < Depth) begin
        exp_q.push_back(8'h30 + 8'(i));
        held++;
      end
      tick();
    end
    idle_inputs();
    n_vec += 2;
    if (bus.uart_data !== 8'h30) begin n_err++; $display("FAIL bp hold data: got %h, expected 30", bus.uart_data); end
    if (bus.cpu_ready !== 1'b0) begin n_err++; $display("FAIL bp full ready: got %b, expected 0", bus.cpu_ready); end
    wait_got(4, 1'b0, ok);
    tick();
    compare_stream("bp");
    n_vec++;
    if (bus.cpu_ready !== 1'b1) begin n_err++; $display("FAIL bp ready after: got %b, expected 1", bus.cpu_ready); end
    pref_m = 1;
  endtask

  task automatic test_timeout();
    got_q.delete();
    exp_q.delete();
    bus.uart_ready = 1'b1;
    bus.cpu_valid = 1'b1; bus.cpu_data = 8'h55; bus.cpu_last = 1'b0;
    tick();  // push 0x55
    idle_inputs();
    tick();  // CPU granted
    n_vec++;
    if (bus.grant !== 2'b01) begin n_err++; $display("FAIL to grant cpu: got %b, expected 01", bus.grant); end
    bus.dbg_valid = 1'b1; bus.dbg_data = 8'h66; bus.dbg_last = 1'b1;
    tick();  // pop 0x55, debug byte queued
    idle_inputs();
    for (int k = 1; k <= Timeout; k++) begin
      tick();
      n_vec++;
      if (bus.grant !== ((k < Timeout) ? 2'b01 : 2'b00)) begin
        n_err++;
        $display("FAIL to grant after %0d empty: got %b, expected %b", k, bus.grant,
                 (k < Timeout) ? 2'b01 : 2'b00);
      end
    end
    tick();
    n_vec += 2;
    if (bus.grant !== 2'b10) begin n_err++; $display("FAIL to grant dbg: got %b, expected 10", bus.grant); end
    if (bus.uart_data !== 8'h66) begin n_err++; $display("FAIL to dbg data: got %h, expected 66", bus.uart_data); end
    repeat (2) tick();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    compare_stream("timeout");
    pref_m = 0;
  endtask

  task automatic test_wrap();
    logic [7:0] vals [3*Depth];
    int idx;
    bit acc, ok;
    got_q.delete();
    exp_q.delete();
    foreach (vals[i]) begin
      vals[i] = 8'($urandom_range(0, 255));
      exp_q.push_back(vals[i]);
    end
    idx = 0;
    for (int c = 0; c < 500 && idx < 3 * Depth; c++) begin
      bus.cpu_valid = 1'b1; bus.cpu_data = vals[idx]; bus.cpu_last = 1'b1;
      bus.uart_ready = 1'($urandom_range(0, 1));
      acc = bus.cpu_ready;
      tick();
      if (acc) idx++;
    end
    idle_inputs();
    wait_got(3 * Depth, 1'b1, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL wrap drain: got %0d bytes, expected %0d", got_q.size(), 3 * Depth); end
    repeat (3) tick();
    compare_stream("wrap");
    pref_m = 1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    got_q.delete();
    exp_q.delete();
    bus.uart_ready = 1'b0;
    bus.cpu_valid = 1'b1; bus.cpu_data = 8'h77; bus.cpu_last = 1'b0;
    tick();
    bus.cpu_data = 8'h78;
    tick();
    idle_inputs();
    tick();
    n_vec++;
    if (bus.uart_valid !== 1'b1) begin n_err++; $display("FAIL rmid valid before: got %b, expected 1", bus.uart_valid); end
    #2 rst = 1'b1;
    #1;
    n_vec += 4;
    if (bus.uart_valid !== 1'b0) begin n_err++; $display("FAIL rmid valid: got %b, expected 0", bus.uart_valid); end
    if (bus.uart_data !== 8'h00) begin n_err++; $display("FAIL rmid data: got %h, expected 00", bus.uart_data); end
    if (bus.grant !== 2'b00) begin n_err++; $display("FAIL rmid grant: got %b, expected 00", bus.grant); end
    if (bus.cpu_ready !== 1'b1) begin n_err++; $display("FAIL rmid cpu_ready: got %b, expected 1", bus.cpu_ready); end
    @(negedge clk);
    rst = 1'b0;
    pref_m = 0;
    bus.uart_ready = 1'b1;
    repeat (6) tick();
    n_vec += 2;
    if (got_q.size() != 0) begin n_err++; $display("FAIL rmid stale: got %0d bytes, expected 0", got_q.size()); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rmid busy: got %b, expected 0", bus.busy); end
    bus.cpu_valid = 1'b1; bus.cpu_data = 8'h5a; bus.cpu_last = 1'b1;
    tick();
    idle_inputs();
    wait_got(1, 1'b0, ok);
    repeat (2) tick();
    exp_q.push_back(8'h5a);
    compare_stream("rmid fresh");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    pref_m = 0;
    test_reset();
    test_single_packet();
    test_contention();
    test_random_rr();
    test_backpressure();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
